// File: rtl/sd_stream_packer_if.sv
// Memory write port between the stream packer (master) and the memory controller (slave).
interface sd_stream_packer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ack);
endinterface

// File: rtl/sd_stream_packer.sv
// Boot preload packer: SD byte stream -> little-endian words -> word FIFO -> memory req/ack port.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_LOAD  | accepting bytes until LOAD_BYTES seen
// S_FLUSH | all bytes in, draining FIFO to memory
// S_DONE  | everything written, held until reset
`ifndef BIN_SIZE
`define BIN_SIZE 32'd0
`endif

module sd_stream_packer #(
    parameter int                WORD_BYTES = 4,
    parameter int                FIFO_DEPTH = 8,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]       LOAD_BYTES = `BIN_SIZE,
    parameter logic [7:0]        PAD_BYTE   = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    sd_stream_packer_if.master mem,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [31:0]        byte_count
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t              state_q;
    logic                busy_q, done_q, overflow_q;
    logic [31:0]         byte_count_q;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DATA_W-1:0]   word_q, word_d, push_word;
    logic [ADDR_W-1:0]   push_addr_q;
    logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                accept, last_byte, push, pop, full, push_ok, drop;

    always_comb begin
        accept    = (state_q == S_LOAD) && start && in_valid;
        last_byte = accept && (byte_count_q == LOAD_BYTES - 32'd1);
        push      = accept && ((lane_q == LANE_W'(WORD_BYTES - 1)) || last_byte);
        pop       = mem_req_q && mem.mem_ack;
        full      = (cnt_q == CNT_W'(FIFO_DEPTH));
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;

        // Lanes above the current one only matter on the final, partial word.
        push_word = word_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (LANE_W'(k) == lane_q)
                push_word[8*k +: 8] = in_byte;
            else if (last_byte && (LANE_W'(k) > lane_q))
                push_word[8*k +: 8] = PAD_BYTE;
        end

        word_d = accept ? push_word : word_q;
        lane_d = lane_q;
        if (accept)
            lane_d = push ? '0 : lane_q + LANE_W'(1);

        cnt_d     = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        mem_req_d = (cnt_d != '0);

        // Present the new FIFO head; if it is the word being pushed now, bypass the array.
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (mem_req_d) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                mem_addr_d  = push_addr_q;
                mem_wdata_d = push_word;
            end else begin
                mem_addr_d  = fifo_addr[rd_ptr_d];
                mem_wdata_d = fifo_data[rd_ptr_d];
            end
        end else if (pop) begin
            mem_addr_d = mem_addr_q + ADDR_W'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr_q] <= push_word;
            fifo_addr[wr_ptr_q] <= push_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            push_addr_q  <= BASE_ADDR;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            byte_count_q <= byte_count_q + 32'(accept);
            lane_q       <= lane_d;
            word_q       <= word_d;
            // Dropped words still consume an address, leaving a hole in memory.
            if (push)
                push_addr_q <= push_addr_q + ADDR_W'(WORD_BYTES);
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overflow_q  <= overflow_q | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (LOAD_BYTES == 32'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (last_byte)
                        state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (cnt_d == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_DONE;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign byte_count    = byte_count_q;
endmodule

// File: tb/tb_sd_stream_packer.sv
// Directed bench for sd_stream_packer: four configurations exercised one after another.
module tb_sd_stream_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [4];
    logic        start  [4];
    logic        in_v   [4];
    logic [7:0]  in_b   [4];
    logic        ack    [4];
    logic        busy_s [4];
    logic        done_s [4];
    logic        ovf_s  [4];
    logic [31:0] bc_s   [4];
    logic        req_s  [4];
    logic [31:0] addr_s [4];
    logic [31:0] data_s [4];

    typedef struct { int k; logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t wlog[$];
    logic seen_req3 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    sd_stream_packer_if #(.ADDR_W(32), .DATA_W(32)) mif0 ();
    sd_stream_packer_if #(.ADDR_W(32), .DATA_W(32)) mif1 ();
    sd_stream_packer_if #(.ADDR_W(32), .DATA_W(32)) mif2 ();
    sd_stream_packer_if #(.ADDR_W(32), .DATA_W(32)) mif3 ();

    assign mif0.mem_ack = ack[0];
    assign mif1.mem_ack = ack[1];
    assign mif2.mem_ack = ack[2];
    assign mif3.mem_ack = ack[3];
    assign req_s[0] = mif0.mem_req; assign addr_s[0] = mif0.mem_addr; assign data_s[0] = mif0.mem_wdata;
    assign req_s[1] = mif1.mem_req; assign addr_s[1] = mif1.mem_addr; assign data_s[1] = mif1.mem_wdata;
    assign req_s[2] = mif2.mem_req; assign addr_s[2] = mif2.mem_addr; assign data_s[2] = mif2.mem_wdata;
    assign req_s[3] = mif3.mem_req; assign addr_s[3] = mif3.mem_addr; assign data_s[3] = mif3.mem_wdata;

    sd_stream_packer #(.WORD_BYTES(4), .FIFO_DEPTH(8), .ADDR_W(32), .BASE_ADDR(32'h0),
                       .LOAD_BYTES(32'd8), .PAD_BYTE(8'h00)) u_a (
        .clk(clk), .reset(rst[0]), .start(start[0]), .in_valid(in_v[0]), .in_byte(in_b[0]),
        .mem(mif0), .busy(busy_s[0]), .done(done_s[0]), .overflow(ovf_s[0]), .byte_count(bc_s[0]));

    sd_stream_packer #(.WORD_BYTES(4), .FIFO_DEPTH(8), .ADDR_W(32), .BASE_ADDR(32'h0),
                       .LOAD_BYTES(32'd6), .PAD_BYTE(8'h00)) u_b (
        .clk(clk), .reset(rst[1]), .start(start[1]), .in_valid(in_v[1]), .in_byte(in_b[1]),
        .mem(mif1), .busy(busy_s[1]), .done(done_s[1]), .overflow(ovf_s[1]), .byte_count(bc_s[1]));

    sd_stream_packer #(.WORD_BYTES(4), .FIFO_DEPTH(2), .ADDR_W(32), .BASE_ADDR(32'h0),
                       .LOAD_BYTES(32'd16), .PAD_BYTE(8'h00)) u_c (
        .clk(clk), .reset(rst[2]), .start(start[2]), .in_valid(in_v[2]), .in_byte(in_b[2]),
        .mem(mif2), .busy(busy_s[2]), .done(done_s[2]), .overflow(ovf_s[2]), .byte_count(bc_s[2]));

    sd_stream_packer #(.WORD_BYTES(4), .FIFO_DEPTH(8), .ADDR_W(32), .BASE_ADDR(32'h0),
                       .LOAD_BYTES(32'd0), .PAD_BYTE(8'h00)) u_d (
        .clk(clk), .reset(rst[3]), .start(start[3]), .in_valid(in_v[3]), .in_byte(in_b[3]),
        .mem(mif3), .busy(busy_s[3]), .done(done_s[3]), .overflow(ovf_s[3]), .byte_count(bc_s[3]));

    // A transfer seen on the falling edge completes on the following rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (req_s[k] && ack[k])
                wlog.push_back('{k, addr_s[k], data_s[k]});
        if (req_s[3])
            seen_req3 = 1'b1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        in_v[k] = 1'b1;
        in_b[k] = b;
        step();
        in_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && !done_s[k]; i++)
            step();
        check_val(tag, 64'(done_s[k]), 64'd1);
    endtask

    task automatic check_writes(input int k, input int n, input string tag,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1);
        wr_t sel[$];
        foreach (wlog[i])
            if (wlog[i].k == k)
                sel.push_back(wlog[i]);
        check_val({tag, "_nwr"}, 64'(sel.size()), 64'(n));
        if (sel.size() > 0) begin
            check_val({tag, "_a0"}, 64'(sel[0].a), 64'(a0));
            check_val({tag, "_d0"}, 64'(sel[0].d), 64'(d0));
        end
        if (sel.size() > 1) begin
            check_val({tag, "_a1"}, 64'(sel[1].a), 64'(a1));
            check_val({tag, "_d1"}, 64'(sel[1].d), 64'(d1));
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; in_v[k] = 1'b0; in_b[k] = 8'h00; ack[k] = 1'b0;
        end
        step(); step();
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        step();

        // Reset state of the basic configuration
        check_val("rst_req",  64'(req_s[0]),  64'd0);
        check_val("rst_addr", 64'(addr_s[0]), 64'd0);
        check_val("rst_data", 64'(data_s[0]), 64'd0);
        check_val("rst_busy", 64'(busy_s[0]), 64'd0);
        check_val("rst_done", 64'(done_s[0]), 64'd0);
        check_val("rst_bc",   64'(bc_s[0]),   64'd0);

        // 8 bytes, ack always high
        ack[0] = 1'b1; start[0] = 1'b1;
        step();
        check_val("a_busy", 64'(busy_s[0]), 64'd1);
        for (int i = 1; i <= 4; i++) send_byte(0, 8'(i));
        check_val("a_req1",  64'(req_s[0]),  64'd1);
        check_val("a_data1", 64'(data_s[0]), 64'h04030201);
        for (int i = 5; i <= 8; i++) send_byte(0, 8'(i));
        wait_done(0, 20, "a_done");
        check_val("a_busy_end", 64'(busy_s[0]), 64'd0);
        check_val("a_ovf",      64'(ovf_s[0]),  64'd0);
        check_val("a_bc",       64'(bc_s[0]),   64'd8);
        check_writes(0, 2, "a", 32'h0, 32'h04030201, 32'h4, 32'h08070605);

        // 6 bytes, padded final word, extra byte ignored
        ack[1] = 1'b1; start[1] = 1'b1;
        step();
        for (int i = 0; i < 6; i++) send_byte(1, 8'hAA + 8'(i));
        send_byte(1, 8'h11);
        wait_done(1, 20, "b_done");
        check_val("b_bc", 64'(bc_s[1]), 64'd6);
        check_writes(1, 2, "b", 32'h0, 32'hADACABAA, 32'h4, 32'h0000AFAE);

        // start low: bytes ignored
        for (int i = 0; i < 3; i++) send_byte(2, 8'hEE);
        check_val("c_nostart_bc",  64'(bc_s[2]),  64'd0);
        check_val("c_nostart_req", 64'(req_s[2]), 64'd0);

        // depth 2, ack held low -> overflow on third word
        start[2] = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) send_byte(2, 8'(i));
        check_val("c_ovf_2w", 64'(ovf_s[2]), 64'd0);
        for (int i = 9; i <= 12; i++) send_byte(2, 8'(i));
        check_val("c_ovf_3w", 64'(ovf_s[2]), 64'd1);
        for (int i = 13; i <= 16; i++) send_byte(2, 8'(i));
        check_val("c_hold_req",  64'(req_s[2]),  64'd1);
        check_val("c_hold_addr", 64'(addr_s[2]), 64'h0);
        check_val("c_hold_data", 64'(data_s[2]), 64'h04030201);
        check_val("c_done_early", 64'(done_s[2]), 64'd0);
        ack[2] = 1'b1;
        wait_done(2, 20, "c_done");
        check_val("c_bc", 64'(bc_s[2]), 64'd16);
        check_writes(2, 2, "c", 32'h0, 32'h04030201, 32'h4, 32'h08070605);

        // Reset mid-load with a request pending
        rst[0] = 1'b1; step(); rst[0] = 1'b0;
        ack[0] = 1'b0; start[0] = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) send_byte(0, 8'h40 + 8'(i));
        check_val("r_req_pre", 64'(req_s[0]), 64'd1);
        rst[0] = 1'b1;
        step();
        check_val("r_req",  64'(req_s[0]),  64'd0);
        check_val("r_bc",   64'(bc_s[0]),   64'd0);
        check_val("r_addr", 64'(addr_s[0]), 64'h0);
        rst[0] = 1'b0; start[0] = 1'b0;

        // LOAD_BYTES = 0
        start[3] = 1'b1;
        step();
        check_val("d_done", 64'(done_s[3]), 64'd1);
        for (int i = 0; i < 5; i++) step();
        check_val("d_noreq", 64'(seen_req3), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
